// File: rtl/vai_pkg.sv
// Shared types and helpers for the VAI serve Tx path.
// Carries a compact CCI-P Tx view plus per-channel FIFO entries.
package vai_pkg;

  localparam int CCIP_CLADDR_WIDTH = 42;

  typedef struct packed {
    logic [1:0]                   vc_sel;
    logic [1:0]                   cl_len;
    logic [3:0]                   req_type;
    logic [CCIP_CLADDR_WIDTH-1:0] address;
    logic [15:0]                  mdata;
  } t_ccip_c0_ReqMemHdr;

  typedef struct packed {
    logic [1:0]                   vc_sel;
    logic                         sop;
    logic [1:0]                   cl_len;
    logic [3:0]                   req_type;
    logic [CCIP_CLADDR_WIDTH-1:0] address;
    logic [15:0]                  mdata;
  } t_ccip_c1_ReqMemHdr;

  typedef struct packed {
    logic [8:0] tid;
  } t_ccip_c2_RspMmioHdr;

  typedef struct packed {
    t_ccip_c0_ReqMemHdr hdr;
    logic               valid;
  } t_if_ccip_c0_Tx;

  typedef struct packed {
    t_ccip_c1_ReqMemHdr hdr;
    logic [511:0]       data;
    logic               valid;
  } t_if_ccip_c1_Tx;

  typedef struct packed {
    t_ccip_c2_RspMmioHdr hdr;
    logic [63:0]         data;
    logic                mmioRdValid;
  } t_if_ccip_c2_Tx;

  typedef struct packed {
    t_if_ccip_c0_Tx c0;
    t_if_ccip_c1_Tx c1;
    t_if_ccip_c2_Tx c2;
  } t_if_ccip_Tx;

  typedef struct packed {
    t_ccip_c0_ReqMemHdr hdr;
  } t_vai_c0_entry;

  typedef struct packed {
    t_ccip_c1_ReqMemHdr hdr;
    logic [511:0]       data;
  } t_vai_c1_entry;

  typedef enum logic {
    C1_IDLE,
    C1_LOCK
  } t_c1_state;

  function automatic int vmid_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // First requester after ptr, wrapping; ptr itself is checked last.
  function automatic int rr_next(
    input logic [63:0] req,
    input int          n,
    input int          ptr
  );
    int sel;
    sel = ptr;
    for (int i = n; i >= 1; i--) begin
      if (req[(ptr + i) % n]) sel = (ptr + i) % n;
    end
    return sel;
  endfunction

endpackage

// File: rtl/vai_tx_fifo.sv
// Synchronous show-ahead FIFO with occupancy count.
// Pushes into a full FIFO are dropped.
module vai_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rp];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop) rp <= rp + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end

endmodule

// File: rtl/vai_serve_tx.sv
// Merges sub-AFU and manager CCI-P Tx ports into one upstream port,
// tagging vmid into mdata and relocating addresses per AFU.
module vai_serve_tx
  import vai_pkg::*;
#(
  parameter int NUM_SUB_AFUS  = 8,
  parameter int FIFO_DEPTH    = 8,
  parameter int ALMFULL_SLACK = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  t_if_ccip_Tx             afu_TxPort [NUM_SUB_AFUS],
  input  t_if_ccip_Tx             mgr_TxPort,
  input  logic [63:0]             offset_array [NUM_SUB_AFUS],
  input  logic                    up_c0TxAlmFull,
  input  logic                    up_c1TxAlmFull,
  output t_if_ccip_Tx             up_TxPort,
  output logic [NUM_SUB_AFUS-1:0] afu_c0_almfull,
  output logic [NUM_SUB_AFUS-1:0] afu_c1_almfull,
  output logic                    c2_overflow
);
  localparam int VMID_WIDTH = vmid_width(NUM_SUB_AFUS);
  localparam int CW         = $clog2(FIFO_DEPTH) + 1;
  localparam int ALM_TH     = FIFO_DEPTH - ALMFULL_SLACK;

  t_vai_c0_entry           c0_head [NUM_SUB_AFUS];
  t_vai_c1_entry           c1_head [NUM_SUB_AFUS];
  logic [CW-1:0]           c0_cnt  [NUM_SUB_AFUS];
  logic [CW-1:0]           c1_cnt  [NUM_SUB_AFUS];
  logic [NUM_SUB_AFUS-1:0] c0_empty, c1_empty;
  logic [NUM_SUB_AFUS-1:0] c0_pop, c1_pop;

  for (genvar n = 0; n < NUM_SUB_AFUS; n++) begin : g_afu
    logic c0_full, c1_full;
    logic unused_n;
    assign unused_n = ^{offset_array[n][63:CCIP_CLADDR_WIDTH],
                        c0_full, c1_full};

    vai_tx_fifo #(.WIDTH($bits(t_vai_c0_entry)), .DEPTH(FIFO_DEPTH)) u_c0 (
      .clk(clk), .reset_n(reset_n),
      .push(afu_TxPort[n].c0.valid), .din(afu_TxPort[n].c0.hdr),
      .pop(c0_pop[n]), .dout(c0_head[n]), .count(c0_cnt[n]),
      .full(c0_full), .empty(c0_empty[n]));

    vai_tx_fifo #(.WIDTH($bits(t_vai_c1_entry)), .DEPTH(FIFO_DEPTH)) u_c1 (
      .clk(clk), .reset_n(reset_n),
      .push(afu_TxPort[n].c1.valid),
      .din({afu_TxPort[n].c1.hdr, afu_TxPort[n].c1.data}),
      .pop(c1_pop[n]), .dout(c1_head[n]), .count(c1_cnt[n]),
      .full(c1_full), .empty(c1_empty[n]));
  end

  logic unused_mgr;
  assign unused_mgr = ^{mgr_TxPort.c0, mgr_TxPort.c1};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      afu_c0_almfull <= '0;
      afu_c1_almfull <= '0;
    end else begin
      for (int n = 0; n < NUM_SUB_AFUS; n++) begin
        afu_c0_almfull[n] <= (c0_cnt[n] >= CW'(ALM_TH));
        afu_c1_almfull[n] <= (c1_cnt[n] >= CW'(ALM_TH));
      end
    end
  end

  // c0 round-robin grant
  logic [63:0]           c0_req;
  logic [VMID_WIDTH-1:0] rr0, c0_sel;
  logic                  c0_go;

  always_comb begin
    c0_req = '0;
    c0_req[NUM_SUB_AFUS-1:0] = ~c0_empty;
    c0_sel = VMID_WIDTH'(rr_next(c0_req, NUM_SUB_AFUS, int'(rr0)));
    c0_go  = !up_c0TxAlmFull && (|c0_req);
    c0_pop = '0;
    c0_pop[c0_sel] = c0_go;
  end

  // c1 grant with multi-CL lock
  t_c1_state             c1_st, c1_st_nx;
  logic [63:0]           c1_req;
  logic [VMID_WIDTH-1:0] rr1, c1_sel, lock_id, lock_id_nx;
  logic [1:0]            left, left_nx;
  logic                  c1_go, c1_issue;

  always_comb begin
    c1_req = '0;
    c1_req[NUM_SUB_AFUS-1:0] = ~c1_empty;
    c1_st_nx   = c1_st;
    left_nx    = left;
    lock_id_nx = lock_id;
    c1_sel     = VMID_WIDTH'(rr_next(c1_req, NUM_SUB_AFUS, int'(rr1)));
    c1_go      = 1'b0;
    c1_issue   = 1'b0;
    unique case (c1_st)
      C1_IDLE: begin
        c1_go = !up_c1TxAlmFull && (|c1_req);
        // Orphan continuation beats are popped and dropped
        c1_issue = c1_go && c1_head[c1_sel].hdr.sop;
        if (c1_issue && (c1_head[c1_sel].hdr.cl_len != 2'd0)) begin
          c1_st_nx   = C1_LOCK;
          left_nx    = c1_head[c1_sel].hdr.cl_len;
          lock_id_nx = c1_sel;
        end
      end
      C1_LOCK: begin
        c1_sel   = lock_id;
        c1_go    = !c1_empty[lock_id];
        c1_issue = c1_go;
        if (c1_go) begin
          left_nx = left - 2'd1;
          if (left == 2'd1) c1_st_nx = C1_IDLE;
        end
      end
      default: c1_st_nx = C1_IDLE;
    endcase
    c1_pop = '0;
    c1_pop[c1_sel] = c1_go;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      c1_st   <= C1_IDLE;
      left    <= '0;
      lock_id <= '0;
    end else begin
      c1_st   <= c1_st_nx;
      left    <= left_nx;
      lock_id <= lock_id_nx;
    end
  end

  // Grant registers
  logic                  g0_vld, g1_vld;
  t_vai_c0_entry         g0_ent;
  t_vai_c1_entry         g1_ent;
  logic [VMID_WIDTH-1:0] g0_vmid, g1_vmid;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      g0_vld <= 1'b0; g0_ent <= '0; g0_vmid <= '0; rr0 <= '0;
      g1_vld <= 1'b0; g1_ent <= '0; g1_vmid <= '0; rr1 <= '0;
    end else begin
      g0_vld <= c0_go;
      g1_vld <= c1_issue;
      if (c0_go) begin
        g0_ent  <= c0_head[c0_sel];
        g0_vmid <= c0_sel;
        rr0     <= c0_sel;
      end
      if (c1_go) begin
        g1_ent  <= c1_head[c1_sel];
        g1_vmid <= c1_sel;
        rr1     <= c1_sel;
      end
    end
  end

  t_ccip_c0_ReqMemHdr c0_x;
  t_ccip_c1_ReqMemHdr c1_x;

  always_comb begin
    c0_x = g0_ent.hdr;
    c0_x.address = g0_ent.hdr.address
                 + offset_array[g0_vmid][CCIP_CLADDR_WIDTH-1:0];
    c0_x.mdata[15 -: VMID_WIDTH] = g0_vmid;
    c1_x = g1_ent.hdr;
    c1_x.address = g1_ent.hdr.address
                 + offset_array[g1_vmid][CCIP_CLADDR_WIDTH-1:0];
    c1_x.mdata[15 -: VMID_WIDTH] = g1_vmid;
  end

  // c2 merge: a holder or a fresh response is eligible the same cycle
  t_if_ccip_c2_Tx          hold [NUM_SUB_AFUS];
  t_if_ccip_c2_Tx          c2_src [NUM_SUB_AFUS];
  t_if_ccip_c2_Tx          mgr_hold, mgr_src, c2_out;
  logic [NUM_SUB_AFUS-1:0] hold_v;
  logic                    mgr_v, mgr_go, afu_go;
  logic [63:0]             c2_req;
  logic [VMID_WIDTH-1:0]   rr2, c2_sel;

  always_comb begin
    c2_req = '0;
    for (int n = 0; n < NUM_SUB_AFUS; n++) begin
      c2_src[n] = hold_v[n] ? hold[n] : afu_TxPort[n].c2;
      c2_req[n] = hold_v[n] | afu_TxPort[n].c2.mmioRdValid;
    end
    mgr_src = mgr_v ? mgr_hold : mgr_TxPort.c2;
    mgr_go  = mgr_v | mgr_TxPort.c2.mmioRdValid;
    afu_go  = !mgr_go && (|c2_req);
    c2_sel  = VMID_WIDTH'(rr_next(c2_req, NUM_SUB_AFUS, int'(rr2)));
    c2_out  = '0;
    if (mgr_go) c2_out = mgr_src;
    else if (afu_go) c2_out = c2_src[c2_sel];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mgr_v       <= 1'b0;
      mgr_hold    <= '0;
      hold_v      <= '0;
      rr2         <= '0;
      c2_overflow <= 1'b0;
      for (int n = 0; n < NUM_SUB_AFUS; n++) hold[n] <= '0;
    end else begin
      if (afu_go) rr2 <= c2_sel;
      if (mgr_TxPort.c2.mmioRdValid) begin
        if (mgr_v && !mgr_go) c2_overflow <= 1'b1;
        else if (mgr_v) mgr_hold <= mgr_TxPort.c2;
        else mgr_v <= 1'b0;
      end else if (mgr_go) begin
        mgr_v <= 1'b0;
      end
      if (mgr_TxPort.c2.mmioRdValid && !mgr_v && !mgr_go) begin
        mgr_hold <= mgr_TxPort.c2;
        mgr_v    <= 1'b1;
      end
      for (int n = 0; n < NUM_SUB_AFUS; n++) begin
        if (afu_TxPort[n].c2.mmioRdValid) begin
          if (hold_v[n] && !(afu_go && c2_sel == n)) begin
            c2_overflow <= 1'b1;
          end else if (hold_v[n] || !(afu_go && c2_sel == n)) begin
            hold[n]   <= afu_TxPort[n].c2;
            hold_v[n] <= 1'b1;
          end else begin
            hold_v[n] <= 1'b0;
          end
        end else if (afu_go && c2_sel == n) begin
          hold_v[n] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      up_TxPort <= '0;
    end else begin
      up_TxPort.c0.hdr   <= c0_x;
      up_TxPort.c0.valid <= g0_vld;
      up_TxPort.c1.hdr   <= c1_x;
      up_TxPort.c1.data  <= g1_ent.data;
      up_TxPort.c1.valid <= g1_vld;
      up_TxPort.c2       <= c2_out;
    end
  end

endmodule
